// File: rtl/cpu_seq_pkg.sv
// Shared encodings for the CPU control sequencer and the instruction decoder.
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_FWAIT  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_MWAIT  = 3'd5,
    S_IRQ    = 3'd6,
    S_HALT   = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    ITYPE_ALU    = 3'd0,
    ITYPE_CMP    = 3'd1,
    ITYPE_LOAD   = 3'd2,
    ITYPE_STORE  = 3'd3,
    ITYPE_BRANCH = 3'd4,
    ITYPE_JAL    = 3'd5,
    ITYPE_HALT   = 3'd6,
    ITYPE_IRET   = 3'd7
  } itype_e;

endpackage

// File: rtl/cpu_sequencer_p_mem_wait_timer.sv
// Loadable down-counter that holds at zero; done is high while the count is zero.
module mem_wait_timer #(
  parameter int WAIT_CNT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [WAIT_CNT_W-1:0] load_val_i,
  output logic                  done_o
);

  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - WAIT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/cpu_sequencer_p.sv
// Multi-cycle CPU control sequencer with BRAM wait states, ready handshake,
// halt and a single maskable interrupt with return.
module cpu_sequencer_p
  import cpu_seq_pkg::*;
#(
  parameter int MEM_WAIT   = 1,
  parameter int WAIT_CNT_W = 4,
  parameter int IRQ_EN     = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] instr_type,
  input  logic       mem_ready,
  input  logic       irq,
  output logic       pc_enable,
  output logic       vec_load,
  output logic       ir_enable,
  output logic       r_enable,
  output logic       alu_bus_enable,
  output logic       reg_read,
  output logic       wrt_brm_en,
  output logic       flags_enable,
  output logic       link_en,
  output logic       irq_ack,
  output logic       halted,
  output logic [2:0] state
);

  state_e state_q, state_d;
  logic   irq_mask_q, irq_mask_d;
  logic   tmr_load, tmr_done, boundary;

  mem_wait_timer #(.WAIT_CNT_W(WAIT_CNT_W)) u_timer (
    .clk        (clk),
    .rst_n      (reset),
    .load_i     (tmr_load),
    .load_val_i (WAIT_CNT_W'(MEM_WAIT)),
    .done_o     (tmr_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_FETCH;
      irq_mask_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      irq_mask_q <= irq_mask_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    irq_mask_d     = irq_mask_q;
    tmr_load       = 1'b0;
    boundary       = 1'b0;
    pc_enable      = 1'b0;
    vec_load       = 1'b0;
    ir_enable      = 1'b0;
    r_enable       = 1'b0;
    alu_bus_enable = 1'b0;
    reg_read       = 1'b0;
    wrt_brm_en     = 1'b0;
    flags_enable   = 1'b0;
    link_en        = 1'b0;
    irq_ack        = 1'b0;
    halted         = 1'b0;

    case (state_q)
      S_FETCH: begin
        tmr_load = 1'b1;
        state_d  = S_FWAIT;
      end
      S_FWAIT: begin
        if (tmr_done && mem_ready) begin
          ir_enable = 1'b1;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        case (instr_type)
          ITYPE_ALU: begin
            r_enable       = 1'b1;
            alu_bus_enable = 1'b1;
            flags_enable   = 1'b1;
            pc_enable      = 1'b1;
            boundary       = 1'b1;
          end
          ITYPE_CMP: begin
            flags_enable = 1'b1;
            pc_enable    = 1'b1;
            boundary     = 1'b1;
          end
          ITYPE_BRANCH: begin
            pc_enable = 1'b1;
            boundary  = 1'b1;
          end
          ITYPE_JAL: begin
            link_en   = 1'b1;
            r_enable  = 1'b1;
            pc_enable = 1'b1;
            boundary  = 1'b1;
          end
          ITYPE_IRET: begin
            pc_enable  = 1'b1;
            irq_mask_d = 1'b0;
            boundary   = 1'b1;
          end
          ITYPE_LOAD, ITYPE_STORE: state_d = S_MEM;
          ITYPE_HALT:              state_d = S_HALT;
          default:                 state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        reg_read   = 1'b1;
        wrt_brm_en = (instr_type == ITYPE_STORE);
        tmr_load   = 1'b1;
        state_d    = S_MWAIT;
      end
      S_MWAIT: begin
        reg_read = 1'b1;
        if (tmr_done && mem_ready) begin
          r_enable  = (instr_type == ITYPE_LOAD);
          pc_enable = 1'b1;
          boundary  = 1'b1;
        end
      end
      S_IRQ: begin
        // Return address goes to r15 through the link path while PC takes the vector.
        link_en    = 1'b1;
        r_enable   = 1'b1;
        pc_enable  = 1'b1;
        vec_load   = (IRQ_EN != 0);
        irq_ack    = (IRQ_EN != 0);
        irq_mask_d = 1'b1;
        state_d    = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: state_d = S_FETCH;
    endcase

    // Mask is taken from its next value so an IRET at the boundary unmasks immediately.
    if (boundary) begin
      state_d = ((IRQ_EN != 0) && irq && !irq_mask_d) ? S_IRQ : S_FETCH;
    end
  end

  assign state = state_q;

endmodule

// File: doc/cpu_sequencer_p.md
Name: cpu_sequencer_p

Overview:
Parametrised multi-cycle control sequencer for the 16-bit CPU. It generalises the fixed-timing CPU control FSM with configurable BRAM wait states, a memory-ready handshake, a halt state and a single maskable interrupt with return. It drives the same enables the CPU datapath already consumes (PC, IR, register write, ALU-bus select, BRAM write, flags, link), plus an interrupt-vector load.

Parameters:
MEM_WAIT, 1, number of wait cycles after a BRAM access before mem_ready is honoured (0..15)
WAIT_CNT_W, 4, width of the wait counter; must satisfy 2^WAIT_CNT_W > MEM_WAIT
IRQ_EN, 1, 1 enables interrupt logic; 0 ties irq_ack and vec_load low and never enters S_IRQ

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
instr_type  in  3  from decoder: 0 ALU, 1 CMP, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 HALT, 7 IRET
mem_ready  in  1  BRAM data valid / write accepted
irq  in  1  level interrupt request
pc_enable  out  1  load PC from displacement path
vec_load  out  1  load PC with interrupt vector (same cycle as pc_enable)
ir_enable  out  1  capture instruction register
r_enable  out  1  register bank write strobe
alu_bus_enable  out  1  1 = ALU drives bus, 0 = memory/link path
reg_read  out  1  1 = BRAM address from register, 0 = from PC
wrt_brm_en  out  1  BRAM port-A write strobe
flags_enable  out  1  flag register write strobe
link_en  out  1  select link value onto memory/link path
irq_ack  out  1  one-cycle interrupt acknowledge
halted  out  1  high while in S_HALT
state  out  3  current state encoding, debug

Behaviour:
- States: S_FETCH, S_FWAIT, S_DECODE, S_EXEC, S_MEM, S_MWAIT, S_IRQ, S_HALT.
- Reset (reset=0, async): state=S_FETCH, wait counter=0, irq_mask=0; all outputs 0 except state.
- All outputs are Moore decodes of the state plus the exit condition; default 0.
- S_FETCH: reg_read=0, counter loaded with MEM_WAIT -> S_FWAIT.
- S_FWAIT: counter decrements to 0; when counter==0 and mem_ready: ir_enable=1 -> S_DECODE; otherwise stay (unbounded stall).
- S_DECODE: one cycle -> S_EXEC.
- S_EXEC by instr_type:
  - ALU: r_enable, alu_bus_enable, flags_enable, pc_enable.
  - CMP: flags_enable, pc_enable.
  - BRANCH: pc_enable.
  - JAL: link_en, r_enable, pc_enable.
  - IRET: pc_enable, clear irq_mask.
  - Each of the above then goes to the instruction boundary.
  - LOAD/STORE: -> S_MEM.
  - HALT: -> S_HALT.
- S_MEM: reg_read=1; STORE asserts wrt_brm_en for exactly this cycle; counter loaded with MEM_WAIT -> S_MWAIT.
- S_MWAIT: reg_read=1; when counter==0 and mem_ready: LOAD asserts r_enable (alu_bus_enable=0); both assert pc_enable -> instruction boundary.
- Instruction boundary: if IRQ_EN and irq and !irq_mask -> S_IRQ, else -> S_FETCH.
- S_IRQ (one cycle): link_en, r_enable (link written to r15), pc_enable, vec_load, irq_ack; set irq_mask -> S_FETCH.
- S_HALT: halted=1, no enables; leave only by reset. An irq in S_HALT is ignored.
- MEM_WAIT=0: the S_FWAIT/S_MWAIT exit depends on mem_ready only. Minimum latency is 4 cycles for ALU (FETCH, FWAIT, DECODE, EXEC) and 6 for LOAD.
- irq is sampled only at boundaries; irq rising mid-instruction is serviced after that instruction completes.
- IRET and irq at the same boundary: the mask clears in the IRET cycle, so the irq is taken immediately.
- Reset asserted mid-instruction aborts it; no strobe is issued after reset falls.

Decomposition:
- Shared package cpu_seq_pkg holds:
  - the state encoding constants (S_FETCH=0 .. S_HALT=7);
  - the instr_type codes (ITYPE_ALU .. ITYPE_IRET).
- The decoder uses the same instr_type codes.
- One natural sub-module, mem_wait_timer: loadable down-counter of width WAIT_CNT_W with a done flag, reused for the fetch and memory waits.

Test Plan:
- MEM_WAIT=1, mem_ready=1, ALU instr: ir_enable at cycle 2, then r_enable+flags_enable+pc_enable together at cycle 4 after FETCH; no other strobes.
- MEM_WAIT=2, LOAD, mem_ready low for 3 extra cycles: reg_read held high throughout S_MWAIT; r_enable with alu_bus_enable=0 only on the cycle mem_ready=1.
- STORE: wrt_brm_en high for exactly 1 cycle in S_MEM with reg_read=1; pc_enable after the wait completes.
- irq=1 during LOAD: LOAD completes, then S_IRQ with irq_ack+vec_load+link_en+r_enable; a second irq is ignored until IRET, then taken at the next boundary.
- HALT: halted=1 permanently; irq toggling produces no strobes; reset=0 returns to S_FETCH with all outputs 0.
- Reset asserted asynchronously mid-S_MWAIT: outputs drop to 0 without waiting for a clk edge; state=S_FETCH.
